// File: rtl/display_pkg.sv
// Shared types and defaults for the byte display latch.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      FLASH = 2'd2
   } disp_state_t;

   localparam int DEF_HOLD_CLKS  = 25_000_000;
   localparam int DEF_FLASH_CLKS = 2_500_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/display_timer.sv
// Clearable saturating up-counter; done is high while count sits at term.
module display_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         done
);

   logic [W-1:0] count;

   assign done = (count == term);

   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (en && !done)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/byte_display_latch.sv
// Latches received bytes onto two hex digits, holds them lit for a while,
// and blanks briefly when the same byte arrives twice in a row.
module byte_display_latch
   import display_pkg::*;
#(
   parameter int HOLD_CLKS  = DEF_HOLD_CLKS,
   parameter int FLASH_CLKS = DEF_FLASH_CLKS
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   output logic [3:0] o_Upper_Nibble,
   output logic [3:0] o_Lower_Nibble,
   output logic       o_Blank,
   output logic       o_Update
);

   localparam int MAX_CLKS = max_int(HOLD_CLKS, FLASH_CLKS);
   localparam int TW       = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
   localparam logic [TW-1:0] HOLD_TERM  = TW'(HOLD_CLKS - 1);
   localparam logic [TW-1:0] FLASH_TERM = TW'(FLASH_CLKS - 1);

   disp_state_t   state, next_state;
   logic          tmr_clr, tmr_done;
   logic [TW-1:0] tmr_term;
   logic [7:0]    latched;

   assign latched  = {o_Upper_Nibble, o_Lower_Nibble};
   assign tmr_term = (state == FLASH) ? FLASH_TERM : HOLD_TERM;

   // A new byte always wins over an expiring timer.
   always_comb begin
      next_state = state;
      tmr_clr    = 1'b0;
      if (i_RX_DV) begin
         tmr_clr = 1'b1;
         if (state != IDLE && i_RX_Byte == latched)
            next_state = FLASH;
         else
            next_state = SHOW;
      end else begin
         case (state)
            IDLE:    tmr_clr = 1'b1;
            SHOW:    if (tmr_done) next_state = IDLE;
            FLASH:   if (tmr_done) begin
                        next_state = SHOW;
                        tmr_clr    = 1'b1;
                     end
            default: next_state = IDLE;
         endcase
      end
   end

   display_timer #(.W(TW)) u_timer (
      .clk  (i_Clk),
      .clr  (i_Rst | tmr_clr),
      .en   (state != IDLE),
      .term (tmr_term),
      .done (tmr_done)
   );

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state          <= IDLE;
         o_Upper_Nibble <= 4'h0;
         o_Lower_Nibble <= 4'h0;
         o_Blank        <= 1'b1;
         o_Update       <= 1'b0;
      end else begin
         state    <= next_state;
         o_Update <= i_RX_DV;
         o_Blank  <= (next_state != SHOW);
         if (i_RX_DV) begin
            o_Upper_Nibble <= i_RX_Byte[7:4];
            o_Lower_Nibble <= i_RX_Byte[3:0];
         end
      end
   end

endmodule
